sat_narrower: RTL and testbench
===============================

# sat_narrower

Signed saturating narrower: the inverse of the sign-extending left padder. Converts wide signed accumulator words (e.g. 32-bit SPGD control/gradient sums) back to a narrow signed DAC/actuator code by dropping R_SHIFT LSBs with rounding, then clamping to OUT_WIDTH bits. It is a two-stage valid/ready pipeline between the accumulator datapath and the DAC output stage, and it keeps saturation statistics for software.

## Interface
- IN_WIDTH, 32, input word width (signed two's complement)
- OUT_WIDTH, 12, output code width (signed); requires OUT_WIDTH <= IN_WIDTH - R_SHIFT
- R_SHIFT, 4, LSBs discarded before clamping; 0 allowed (no rounding add)
- CNT_WIDTH, 16, width of saturation event counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  IN_WIDTH  signed input sample
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts input this cycle
- out_data  out  OUT_WIDTH  signed narrowed sample
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts output
- out_sat  out  1  current out_data was clipped (qualified by out_valid)
- sat_hi  out  1  sticky: a positive clip was delivered
- sat_lo  out  1  sticky: a negative clip was delivered
- sat_count  out  CNT_WIDTH  clipped samples delivered; saturates at all-ones
- sat_clr  in  1  synchronous clear of sat_hi, sat_lo, sat_count

## Operation
- Transfer on a port when valid && ready in the same cycle.
- Pipeline advance: adv = !out_valid || out_ready; in_ready = adv && rst_n. Both stages move together on adv; no bubble squeezing required.
- Stage 1 (round): sign-extend in_data to IN_WIDTH+1 bits; add 2^(R_SHIFT-1) (round-half-up) when R_SHIFT > 0; register the sum and its valid.
- Stage 2 (clamp): arithmetic shift right by R_SHIFT -> IN_WIDTH+1-R_SHIFT bits; if > 2^(OUT_WIDTH-1)-1 output max and flag hi; if < -2^(OUT_WIDTH-1) output min and flag lo; else take low OUT_WIDTH bits. Register out_data, out_sat, clip direction, out_valid.
- On output transfer with out_sat=1: set sat_hi or sat_lo per direction; increment sat_count unless all-ones.
- sat_clr: clears sticky flags and counter; priority over a same-cycle increment/set (result 0).
- Stalled output (out_valid && !out_ready): out_data/out_sat held stable; stage 1 held.

## Timing
- Latency: 2 cycles from input transfer to out_valid with no stall; throughput 1 sample/cycle.
- Reset (rst_n low at clock edge): out_valid=0, out_data=0, out_sat=0, sat_hi=0, sat_lo=0, sat_count=0, stage-1 valid=0; in_ready=0 while rst_n low. In-flight samples discarded; no output transfer during reset.
- in_ready is combinational from out_ready (no skid buffer); downstream must not make out_ready depend on in_ready.
- Counter at all-ones stays all-ones on further clips.

## Configuration
- SAT_NARROW_ROUND_EN defined: round-half-up add in stage 1 as above.
- Not defined: stage 1 passes the sign-extended value unmodified (floor truncation, arithmetic shift only); latency remains 2 cycles.

## Structure
- Shared package spgd_pkg: default widths (SPGD_ACC_WIDTH=32, SPGD_DAC_WIDTH=12, SPGD_DAC_SHIFT=4) and clip-direction enum (CLIP_NONE, CLIP_HI, CLIP_LO).
- One sub-module: sat_event_counter (saturating counter plus sticky hi/lo flags with clear priority).

## Test plan
- Defaults, rounding on: in=0x00000008 -> out_data=0x001, out_sat=0; rounding off -> 0x000.
- in=0x00007FF8 -> 0x7FF, out_sat=1, sat_hi=1, sat_count=1; in=0x00007FF0 -> 0x7FF, out_sat=0.
- in=0x80000000 -> 0x800, sat_lo=1; in=0xFFFFFFF8 -> 0x000 (round) / 0xFFF (no round).
- Back-to-back 8 samples with out_ready low for cycles 3-5: in_ready low while stalled, out_data held, all 8 delivered in order, none lost/duplicated.
- Counter preloaded to 0xFFFF via 65535 clips (or forced) -> further clip keeps 0xFFFF; sat_clr in same cycle as clip -> 0, flags 0.
- rst_n low for one cycle with both stages full -> next cycle out_valid=0, all outputs 0, prior samples never appear.

Source files
------------

// File: rtl/spgd_pkg.sv
// Shared SPGD datapath definitions: default accumulator/DAC widths and the
// clip-direction code passed from the narrower to its statistics block.
package spgd_pkg;

    localparam int SPGD_ACC_WIDTH = 32;
    localparam int SPGD_DAC_WIDTH = 12;
    localparam int SPGD_DAC_SHIFT = 4;

    typedef enum logic [1:0] {
        CLIP_NONE = 2'd0,
        CLIP_HI   = 2'd1,
        CLIP_LO   = 2'd2
    } clip_dir_e;

endpackage

// File: rtl/sat_event_counter.sv
// Saturation statistics: counts delivered clipped samples (sticks at
// all-ones) and keeps sticky positive/negative clip flags. A clear wins over
// an event landing in the same cycle.
module sat_event_counter
    import spgd_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 evt_i,
    input  clip_dir_e            dir_i,
    output logic                 sat_hi_o,
    output logic                 sat_lo_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic                 sat_hi_q, sat_hi_d;
    logic                 sat_lo_q, sat_lo_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Next-state: clear has priority, otherwise record the delivered clip.
    always_comb begin
        sat_hi_d = sat_hi_q;
        sat_lo_d = sat_lo_q;
        count_d  = count_q;
        if (clr_i) begin
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b0;
            count_d  = '0;
        end else if (evt_i) begin
            if (dir_i == CLIP_HI) sat_hi_d = 1'b1;
            if (dir_i == CLIP_LO) sat_lo_d = 1'b1;
            if (count_q != '1) count_d = count_q + 1'b1;
        end
    end

    // Statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sat_hi_q <= sat_hi_d;
            sat_lo_q <= sat_lo_d;
            count_q  <= count_d;
        end
    end

    assign sat_hi_o = sat_hi_q;
    assign sat_lo_o = sat_lo_q;
    assign count_o  = count_q;

endmodule

// File: rtl/sat_narrower.sv
// Signed saturating narrower: wide accumulator word -> narrow DAC code.
// Stage 1 sign-extends (and rounds half-up when SAT_NARROW_ROUND_EN is
// defined, otherwise floors), stage 2 clamps to OUT_WIDTH signed bits.
// Both stages advance together whenever the output is empty or accepted.
module sat_narrower
    import spgd_pkg::*;
#(
    parameter int IN_WIDTH  = SPGD_ACC_WIDTH,
    parameter int OUT_WIDTH = SPGD_DAC_WIDTH,
    parameter int R_SHIFT   = SPGD_DAC_SHIFT,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sat,
    output logic                 sat_hi,
    output logic                 sat_lo,
    output logic [CNT_WIDTH-1:0] sat_count,
    input  logic                 sat_clr
);

    // Width of the value after the rounding LSBs are dropped.
    localparam int SW = IN_WIDTH + 1 - R_SHIFT;

`ifdef SAT_NARROW_ROUND_EN
    localparam int RND_POS = (R_SHIFT > 0) ? (R_SHIFT - 1) : 0;
    localparam logic signed [IN_WIDTH:0] RND =
        (R_SHIFT > 0) ? ((IN_WIDTH+1)'(1) << RND_POS) : '0;
`endif

    logic                   adv;
    logic signed [IN_WIDTH:0] sum;
    logic [SW-1:0]          s1_val_q, s1_val_d;
    logic                   s1_valid_q;
    logic [SW-OUT_WIDTH:0]  top_bits;
    logic                   clip_hi, clip_lo;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q;
    logic                   out_sat_q;
    clip_dir_e              clip_dir_q, clip_dir_d;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && rst_n;

    // Stage-1 arithmetic: only the bits that survive the shift are kept,
    // the discarded LSBs have already contributed their rounding carry.
    always_comb begin
`ifdef SAT_NARROW_ROUND_EN
        sum = $signed({in_data[IN_WIDTH-1], in_data}) + RND;
`else
        sum = $signed({in_data[IN_WIDTH-1], in_data});
`endif
        s1_val_d = SW'(sum >>> R_SHIFT);
    end

    // Stage 1 register: rounded/shifted sample and its valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_val_q   <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            s1_val_q   <= s1_val_d;
        end
    end

    // Clamp: the value fits iff every bit above the output MSB equals the sign.
    always_comb begin
        top_bits   = s1_val_q[SW-1:OUT_WIDTH-1];
        clip_hi    = !s1_val_q[SW-1] && (|top_bits);
        clip_lo    = s1_val_q[SW-1] && !(&top_bits);
        out_data_d = s1_val_q[OUT_WIDTH-1:0];
        clip_dir_d = CLIP_NONE;
        if (clip_hi) begin
            out_data_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            clip_dir_d = CLIP_HI;
        end else if (clip_lo) begin
            out_data_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            clip_dir_d = CLIP_LO;
        end
    end

    // Stage 2 register: output word, clip flag/direction and valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            clip_dir_q  <= CLIP_NONE;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_data_d;
                out_sat_q  <= (clip_dir_d != CLIP_NONE);
                clip_dir_q <= clip_dir_d;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;

    sat_event_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_sat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (sat_clr),
        .evt_i    (out_valid_q && out_ready && out_sat_q),
        .dir_i    (clip_dir_q),
        .sat_hi_o (sat_hi),
        .sat_lo_o (sat_lo),
        .count_o  (sat_count)
    );

endmodule

// File: tb/tb_sat_narrower.sv
// Bench for sat_narrower (default parameters). Builds with or without
// SAT_NARROW_ROUND_EN; expectations follow the same macro.
module tb_sat_narrower;

    localparam int RS = 4;
    localparam longint MAXV = 2047;
    localparam longint MINV = -2048;
`ifdef SAT_NARROW_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk, rst_n;
    logic [31:0] in_data;
    logic        in_valid, in_ready;
    logic [11:0] out_data;
    logic        out_valid, out_ready, out_sat;
    logic        sat_hi, sat_lo, sat_clr;
    logic [15:0] sat_count;

    sat_narrower dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat),
        .sat_hi    (sat_hi),
        .sat_lo    (sat_lo),
        .sat_count (sat_count),
        .sat_clr   (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int delivered = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference narrowing done on plain integers.
    function automatic void model(input logic [31:0] d, output logic [11:0] o,
                                  output bit s, output bit h);
        longint v;
        v = longint'($signed(d));
        if (RND) v = v + (longint'(1) <<< (RS - 1));
        v = v >>> RS;
        s = 1'b0;
        h = 1'b0;
        if (v > MAXV) begin
            o = 12'h7FF; s = 1'b1; h = 1'b1;
        end else if (v < MINV) begin
            o = 12'h800; s = 1'b1;
        end else begin
            o = v[11:0];
        end
    endfunction

    // Model state: samples accepted but not yet delivered, plus statistics.
    logic [31:0] q[$];
    bit          m_hi, m_lo;
    int          m_cnt;
    bit          just_rst;

    // Inputs change 2 time units after the rising edge, so the values seen
    // at the falling edge are the ones the next rising edge will act on.
    always @(negedge clk) begin
        logic [11:0] eo;
        bit es, eh, xs, xh;
        xs = 1'b0;
        xh = 1'b0;
        if (!rst_n) begin
            chk("in_ready_in_reset", in_ready, 0);
            q.delete();
            m_hi = 1'b0;
            m_lo = 1'b0;
            m_cnt = 0;
            just_rst = 1'b1;
        end else begin
            if (just_rst) begin
                chk("post_reset_out_valid", out_valid, 0);
                chk("post_reset_out_data", out_data, 0);
                chk("post_reset_out_sat", out_sat, 0);
                just_rst = 1'b0;
            end
            chk("in_ready_rule", in_ready, (!out_valid || out_ready) ? 1 : 0);
            chk("sat_hi", sat_hi, m_hi);
            chk("sat_lo", sat_lo, m_lo);
            chk("sat_count", sat_count, m_cnt);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    model(q[0], eo, es, eh);
                    chk("out_data", out_data, eo);
                    chk("out_sat", out_sat, es);
                    if (out_ready) begin
                        void'(q.pop_front());
                        delivered++;
                        xs = es;
                        xh = eh;
                    end
                end
            end
            if (sat_clr) begin
                m_hi = 1'b0;
                m_lo = 1'b0;
                m_cnt = 0;
            end else if (xs) begin
                if (xh) m_hi = 1'b1;
                else    m_lo = 1'b1;
                if (m_cnt != 65535) m_cnt++;
            end
            if (in_valid && in_ready) q.push_back(in_data);
        end
    end

    // One sample into an idle pipeline; checks 2-cycle latency and the
    // hand-computed output. Leaves the sample presented with out_ready=1.
    task automatic send_one(input string nm, input logic [31:0] d,
                            input logic [11:0] e, input bit es);
        @(posedge clk); #2;
        in_data = d; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        chk({nm, "_not_early"}, out_valid, 0);
        @(posedge clk); #2;
        chk({nm, "_latency"}, out_valid, 1);
        chk({nm, "_data"}, out_data, e);
        chk({nm, "_sat"}, out_sat, es);
    endtask

    logic [31:0] bv[8];

    initial begin
        int i, c, d0;
        bit acc;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sat_clr = 1'b0;
        bv = '{32'h0000_0010, 32'hFFFF_FFF0, 32'h0001_2345, 32'h7FFF_FFFF,
               32'h8000_0001, 32'h0000_7FF7, 32'hFFFF_8008, 32'h0000_0100};
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sat_count", sat_count, 0);
        chk("idle_in_ready", in_ready, 1);

        send_one("half_lsb", 32'h0000_0008, RND ? 12'h001 : 12'h000, 1'b0);
        @(posedge clk); #2;
        send_one("pos_clip", 32'h0000_7FF8, 12'h7FF, RND);
        @(posedge clk); #2;
        chk("pos_clip_sat_hi", sat_hi, RND);
        chk("pos_clip_count", sat_count, RND ? 1 : 0);
        send_one("pos_max", 32'h0000_7FF0, 12'h7FF, 1'b0);
        @(posedge clk); #2;
        send_one("neg_clip", 32'h8000_0000, 12'h800, 1'b1);
        @(posedge clk); #2;
        chk("neg_clip_sat_lo", sat_lo, 1);
        send_one("neg_half", 32'hFFFF_FFF8, RND ? 12'h000 : 12'hFFF, 1'b0);
        @(posedge clk); #2;

        // Back-to-back burst with output stalled in cycles 3..5.
        i = 0; c = 0; d0 = delivered;
        while ((i < 8 || q.size() > 0 || out_valid) && c < 60) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid = (i < 8);
            if (i < 8) in_data = bv[i];
            #1;
            acc = in_valid && in_ready;
            if (c == 4) chk("stall_in_ready", in_ready, 0);
            @(posedge clk); #2;
            if (acc) i++;
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("burst_drained", (c < 60) ? 1 : 0, 1);
        chk("burst_delivered", delivered - d0, 8);

        // Clear, then drive the counter to all-ones with a clip stream.
        sat_clr = 1'b1;
        @(posedge clk); #2;
        sat_clr = 1'b0;
        chk("clr_count", sat_count, 0);
        in_data = 32'h7FFF_FFFF; in_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #2 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("count_full", sat_count, 16'hFFFF);
        send_one("clip_at_full", 32'h7FFF_FFFF, 12'h7FF, 1'b1);
        @(posedge clk); #2;
        chk("count_stays_full", sat_count, 16'hFFFF);

        // Clip delivered in the same cycle as sat_clr: clear wins.
        send_one("clip_with_clr", 32'h8000_0000, 12'h800, 1'b1);
        sat_clr = 1'b1;
        @(posedge clk); #2;
        sat_clr = 1'b0;
        chk("clr_prio_count", sat_count, 0);
        chk("clr_prio_hi", sat_hi, 0);
        chk("clr_prio_lo", sat_lo, 0);

        // Reset with both stages full; flushed samples must never appear.
        send_one("pre_rst_clip", 32'h7FFF_FFFF, 12'h7FF, 1'b1);
        @(posedge clk); #2;
        out_ready = 1'b0;
        in_data = 32'h7FFF_FFFF; in_valid = 1'b1;
        @(posedge clk); #2;
        in_data = 32'h0000_1230;
        @(posedge clk); #2;
        in_valid = 1'b0;
        chk("full_before_rst", out_valid, 1);
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sat_hi", sat_hi, 0);
        chk("rst_sat_count", sat_count, 0);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        chk("no_ghost_output", out_valid, 0);
        chk("model_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
